// File: rtl/request_encoder.sv
// rtl/request_encoder.sv - registered N-to-log2(N) request encoder with sticky pending flags
//
// Purpose:
//   Collects request pulses or levels into sticky pending flags. It selects one
//   eligible (pending & mask) line, by fixed priority or round-robin, and
//   presents its index on a valid/ready output. Only one index is issued per
//   handshake.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   req_in       in   [WIDTH]      request lines, each high bit sets its pending flag
//   mask_in      in   [WIDTH]      1 = line eligible for selection
//   code_out     out  [CODE_WIDTH] selected index (holds after consumption)
//   code_valid   out  1            code_out holds an issued, unconsumed index
//   code_ready   in   1            consumer accepts code_out this cycle
//   pending_out  out  [WIDTH]      registered pending flags
module request_encoder #(
  parameter int WIDTH       = 16,
  parameter int ROUND_ROBIN = 0,
  localparam int CODE_WIDTH = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      req_in,
  input  logic [WIDTH-1:0]      mask_in,
  output logic [CODE_WIDTH-1:0] code_out,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic [WIDTH-1:0]      pending_out
);

  logic [WIDTH-1:0]      pending_q, pending_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  valid_q, valid_d;
  logic [CODE_WIDTH-1:0] ptr_q;

  logic [WIDTH-1:0]      eligible;
  logic [WIDTH-1:0]      take;
  logic [CODE_WIDTH-1:0] sel;
  logic                  found;
  logic                  load;

  assign eligible = pending_q & mask_in;

  // Search starts at ptr and wraps. With fixed priority ptr is tied to 0, so
  // the same search returns the lowest set bit.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = CODE_WIDTH'(idx);
      end
    end
  end

  assign load = found && (!valid_q || code_ready);
  assign take = load ? (WIDTH'(1) << sel) : '0;

  // A new request on the line being taken re-sets its flag: set wins.
  always_comb begin
    pending_d = (pending_q & ~take) | req_in;
    code_d    = code_q;
    valid_d   = valid_q;
    if (load) begin
      code_d  = sel;
      valid_d = 1'b1;
    end else if (valid_q && code_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      logic [CODE_WIDTH-1:0] ptr_d;

      // The pointer advances past the winner, so that line gets the lowest
      // priority on the next search.
      always_comb begin
        ptr_d = ptr_q;
        if (load) begin
          ptr_d = (sel == CODE_WIDTH'(WIDTH - 1)) ? '0 : sel + CODE_WIDTH'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
      end
    end else begin : g_fp
      assign ptr_q = '0;
    end
  endgenerate

  assign code_out    = code_q;
  assign code_valid  = valid_q;
  assign pending_out = pending_q;

endmodule
